// File: rtl/alarm_bank.sv
// Multi-slot alarm controller: per-slot BCD alarm times, arm bits, ring/snooze/auto-stop FSM.
// Optional hourly chime enabled by defining ALARM_CHIME_EN; otherwise chime is tied low.
module alarm_bank #(
    parameter int unsigned NUM_ALARMS = 4,
    parameter int unsigned SLOT_W     = 2,
    parameter int unsigned RING_SECS  = 60,
    parameter int unsigned SNOOZE_MIN = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick_1hz,
    input  logic [1:0]            mode,
    input  logic                  turn,
    input  logic                  change,
    input  logic [SLOT_W-1:0]     sel,
    input  logic                  arm_tog,
    input  logic                  dismiss,
    input  logic                  snooze,
    input  logic [7:0]            hour,
    input  logic [7:0]            minute,
    input  logic [7:0]            second,
    output logic [7:0]            sel_hour,
    output logic [7:0]            sel_minute,
    output logic [NUM_ALARMS-1:0] armed,
    output logic [SLOT_W-1:0]     active_slot,
    output logic                  alert,
    output logic                  chime
);

    localparam int unsigned     SNZ_W     = 11;
    localparam logic [SNZ_W-1:0] SNZ_LOAD = SNZ_W'(SNOOZE_MIN * 60);
    localparam logic [7:0]      RING_LAST = 8'(RING_SECS);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RING   = 2'd1;
    localparam logic [1:0] SNOOZE = 2'd2;

    logic [7:0] slot_hour [NUM_ALARMS];
    logic [7:0] slot_min  [NUM_ALARMS];

    logic change_q, arm_q, dismiss_q, snooze_q;
    logic change_e, arm_e, dismiss_e, snooze_e;
    logic sel_ok, edit_en;

    logic [1:0]       state, state_d;
    logic [7:0]       ring_cnt, ring_cnt_d;
    logic [SNZ_W-1:0] snz_cnt, snz_cnt_d;
    logic [SLOT_W-1:0] active_d;
    logic             any_match;
    logic [SLOT_W-1:0] match_idx;

    function automatic logic [7:0] bcd_inc_min(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_inc_hour(input logic [7:0] v);
        if (v == 8'h23)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign change_e  = change  & ~change_q;
    assign arm_e     = arm_tog & ~arm_q;
    assign dismiss_e = dismiss & ~dismiss_q;
    assign snooze_e  = snooze  & ~snooze_q;

    assign sel_ok  = (32'(sel) < NUM_ALARMS);
    assign edit_en = (mode == 2'b10) && sel_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            change_q  <= 1'b0;
            arm_q     <= 1'b0;
            dismiss_q <= 1'b0;
            snooze_q  <= 1'b0;
        end else begin
            change_q  <= change;
            arm_q     <= arm_tog;
            dismiss_q <= dismiss;
            snooze_q  <= snooze;
        end
    end

    // Slot storage and arm bits, edited only in alarm-set mode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_ALARMS); i++) begin
                slot_hour[i] <= 8'h00;
                slot_min[i]  <= 8'h00;
            end
            armed <= '0;
        end else if (edit_en) begin
            if (change_e) begin
                if (turn)
                    slot_hour[sel] <= bcd_inc_hour(slot_hour[sel]);
                else
                    slot_min[sel] <= bcd_inc_min(slot_min[sel]);
            end
            if (arm_e)
                armed[sel] <= ~armed[sel];
        end
    end

    always_comb begin
        sel_hour   = 8'h00;
        sel_minute = 8'h00;
        if (sel_ok) begin
            sel_hour   = slot_hour[sel];
            sel_minute = slot_min[sel];
        end
    end

    // Lowest-index armed slot matching the current hour:minute
    always_comb begin
        any_match = 1'b0;
        match_idx = '0;
        for (int i = 0; i < int'(NUM_ALARMS); i++) begin
            if (!any_match && armed[i] && slot_hour[i] == hour && slot_min[i] == minute) begin
                any_match = 1'b1;
                match_idx = SLOT_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ring_cnt    <= 8'd0;
            snz_cnt     <= '0;
            active_slot <= '0;
            alert       <= 1'b0;
        end else begin
            state       <= state_d;
            ring_cnt    <= ring_cnt_d;
            snz_cnt     <= snz_cnt_d;
            active_slot <= active_d;
            alert       <= (state_d == RING);
        end
    end

    // Disarming the active slot cancels a ring or snooze in progress
    always_comb begin
        state_d    = state;
        ring_cnt_d = ring_cnt;
        snz_cnt_d  = snz_cnt;
        active_d   = active_slot;
        case (state)
            IDLE: begin
                if (tick_1hz && second == 8'h00 && any_match) begin
                    state_d    = RING;
                    active_d   = match_idx;
                    ring_cnt_d = 8'd0;
                end
            end
            RING: begin
                if (dismiss_e || !armed[active_slot]) begin
                    state_d = IDLE;
                end else if (snooze_e) begin
                    state_d   = SNOOZE;
                    snz_cnt_d = SNZ_LOAD;
                end else if (tick_1hz) begin
                    ring_cnt_d = ring_cnt + 8'd1;
                    if (ring_cnt + 8'd1 == RING_LAST)
                        state_d = IDLE;
                end
            end
            SNOOZE: begin
                if (dismiss_e || !armed[active_slot]) begin
                    state_d = IDLE;
                end else if (tick_1hz) begin
                    snz_cnt_d = snz_cnt - SNZ_W'(1);
                    if (snz_cnt == SNZ_W'(1)) begin
                        state_d    = RING;
                        ring_cnt_d = 8'd0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ALARM_CHIME_EN
    // Chime holds for one second; a triggering alarm in that second takes priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            chime <= 1'b0;
        else if (tick_1hz)
            chime <= (state == IDLE) && minute == 8'h00 && second == 8'h00 && !any_match;
    end
`else
    assign chime = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_bank.sv
// Scoreboard bench for alarm_bank: stimulus queues expected output values, a negedge monitor checks them.
module tb_alarm_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1hz;
    logic [1:0] mode;
    logic       turn, change, arm_tog, dismiss, snooze;
    logic [1:0] sel;
    logic [7:0] hour, minute, second;
    logic [7:0] sel_hour, sel_minute;
    logic [3:0] armed;
    logic [1:0] active_slot;
    logic       alert, chime;

    int checks   = 0;
    int failures = 0;

    string       q_name [$];
    int          q_kind [$];
    logic [31:0] q_exp  [$];

    string       mon_name;
    int          mon_kind;
    logic [31:0] mon_exp, mon_act;

`ifdef ALARM_CHIME_EN
    localparam logic [31:0] CHIME_EXP = 32'd1;
`else
    localparam logic [31:0] CHIME_EXP = 32'd0;
`endif

    alarm_bank dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .mode(mode), .turn(turn),
        .change(change), .sel(sel), .arm_tog(arm_tog), .dismiss(dismiss), .snooze(snooze),
        .hour(hour), .minute(minute), .second(second),
        .sel_hour(sel_hour), .sel_minute(sel_minute), .armed(armed),
        .active_slot(active_slot), .alert(alert), .chime(chime)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // kinds: 0 sel_hour, 1 sel_minute, 2 armed, 3 active_slot, 4 alert, 5 chime
    always @(negedge clk) begin
        while (q_kind.size() > 0) begin
            mon_name = q_name.pop_front();
            mon_kind = q_kind.pop_front();
            mon_exp  = q_exp.pop_front();
            case (mon_kind)
                0:       mon_act = 32'(sel_hour);
                1:       mon_act = 32'(sel_minute);
                2:       mon_act = 32'(armed);
                3:       mon_act = 32'(active_slot);
                4:       mon_act = 32'(alert);
                default: mon_act = 32'(chime);
            endcase
            checks++;
            if (mon_act !== mon_exp) begin
                failures++;
                $display("FAIL %s: got=%0h expected=%0h", mon_name, mon_act, mon_exp);
            end
        end
    end

    task automatic chk(input string n, input int k, input logic [31:0] e);
        q_name.push_back(n);
        q_kind.push_back(k);
        q_exp.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int which);
        case (which)
            0:       change  = 1'b1;
            1:       arm_tog = 1'b1;
            2:       dismiss = 1'b1;
            default: snooze  = 1'b1;
        endcase
        cyc(1);
        change = 1'b0; arm_tog = 1'b0; dismiss = 1'b0; snooze = 1'b0;
        cyc(1);
    endtask

    task automatic tick();
        tick_1hz = 1'b1;
        cyc(1);
        tick_1hz = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tick_1hz = 1'b0; mode = 2'b00; turn = 1'b0; change = 1'b0;
        sel = 2'd0; arm_tog = 1'b0; dismiss = 1'b0; snooze = 1'b0;
        hour = 8'h00; minute = 8'h00; second = 8'h00;
        cyc(1);
        chk("rst_hour", 0, 32'h00); chk("rst_min", 1, 32'h00); chk("rst_armed", 2, 32'h0);
        chk("rst_slot", 3, 32'h0);  chk("rst_alert", 4, 32'h0); chk("rst_chime", 5, 32'h0);
        cyc(1);
        reset = 1'b0;
        cyc(1);

        // Program slot 1 to 07:30 and arm it
        mode = 2'b10; sel = 2'd1; turn = 1'b1;
        repeat (7) press(0);
        turn = 1'b0;
        repeat (30) press(0);
        press(1);
        chk("cfg_hour", 0, 32'h07); chk("cfg_min", 1, 32'h30); chk("cfg_armed", 2, 32'b0010);

        // Trigger and auto-stop after 60 ticks
        mode = 2'b00; hour = 8'h07; minute = 8'h29; second = 8'h59;
        tick();
        chk("pre_trig_alert", 4, 32'h0);
        minute = 8'h30; second = 8'h00;
        tick();
        chk("trig_alert", 4, 32'h1); chk("trig_slot", 3, 32'h1);
        second = 8'h01;
        repeat (59) tick();
        chk("ring_59_alert", 4, 32'h1);
        tick();
        chk("ring_timeout_alert", 4, 32'h0);
        tick();
        chk("idle_stays", 4, 32'h0);

        // Snooze for 300 ticks, re-ring, then dismiss
        second = 8'h00;
        tick();
        chk("retrig_alert", 4, 32'h1);
        second = 8'h01;
        press(3);
        chk("snoozed_alert", 4, 32'h0);
        repeat (299) tick();
        chk("snooze_299", 4, 32'h0);
        tick();
        chk("snooze_end_ring", 4, 32'h1);
        press(2);
        chk("dismissed", 4, 32'h0);
        repeat (5) tick();
        chk("dismiss_holds", 4, 32'h0);

        // Slots 0 and 2 at 06:00: lowest index wins; dismiss beats snooze
        mode = 2'b10; sel = 2'd0; turn = 1'b1;
        repeat (6) press(0);
        press(1);
        sel = 2'd2;
        repeat (6) press(0);
        press(1);
        chk("armed_three", 2, 32'b0111); chk("slot2_hour", 0, 32'h06);
        mode = 2'b00; hour = 8'h06; minute = 8'h00; second = 8'h00;
        tick();
        chk("dual_alert", 4, 32'h1); chk("dual_slot", 3, 32'h0);
        second = 8'h01;
        dismiss = 1'b1; snooze = 1'b1;
        cyc(1);
        dismiss = 1'b0; snooze = 1'b0;
        cyc(1);
        chk("both_alert", 4, 32'h0);
        repeat (300) tick();
        chk("both_stays_idle", 4, 32'h0);

        // BCD wrap on slot 3
        mode = 2'b10; sel = 2'd3; turn = 1'b1;
        repeat (5) press(0);
        turn = 1'b0;
        repeat (59) press(0);
        chk("min_59", 1, 32'h59);
        press(0);
        chk("min_wrap", 1, 32'h00); chk("min_wrap_hour", 0, 32'h05);
        change = 1'b1;
        cyc(4);
        change = 1'b0;
        cyc(1);
        chk("held_change_once", 1, 32'h01);
        turn = 1'b1;
        repeat (18) press(0);
        chk("hour_23", 0, 32'h23);
        press(0);
        chk("hour_wrap", 0, 32'h00); chk("hour_wrap_min", 1, 32'h01);

        // Disarm the active slot while ringing
        mode = 2'b00; hour = 8'h07; minute = 8'h30; second = 8'h00;
        tick();
        chk("s1_alert", 4, 32'h1); chk("s1_slot", 3, 32'h1);
        second = 8'h01; mode = 2'b10; sel = 2'd1;
        press(1);
        chk("disarm_alert", 4, 32'h0); chk("disarm_armed", 2, 32'b0101);
        repeat (2) tick();
        chk("disarm_stays", 4, 32'h0);

        // Reset while snoozing
        press(1);
        mode = 2'b00; second = 8'h00;
        tick();
        chk("s1b_alert", 4, 32'h1);
        second = 8'h01;
        press(3);
        repeat (10) tick();
        chk("mid_snooze_alert", 4, 32'h0);
        reset = 1'b1;
        chk("mr_hour", 0, 32'h00); chk("mr_min", 1, 32'h00); chk("mr_armed", 2, 32'h0);
        chk("mr_slot", 3, 32'h0);  chk("mr_alert", 4, 32'h0); chk("mr_chime", 5, 32'h0);
        cyc(1);
        reset = 1'b0;
        cyc(1);
        repeat (300) tick();
        chk("post_reset_quiet", 4, 32'h0);

        // Hourly chime with nothing armed
        hour = 8'h08; minute = 8'h59; second = 8'h59;
        tick();
        chk("chime_before", 5, 32'h0);
        hour = 8'h09; minute = 8'h00; second = 8'h00;
        tick();
        second = 8'h01;
        chk("chime_on", 5, CHIME_EXP);
        cyc(3);
        chk("chime_hold", 5, CHIME_EXP);
        tick();
        chk("chime_off", 5, 32'h0);

        cyc(2);
        checks++;
        if (q_kind.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got=%0d pending expected=0", q_kind.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
